// File: rtl/fifo_video_out_pkg.sv
// -----------------------------------------------------------------------------
// fifo_video_out_pkg
// Shared definitions for the FIFO-fed video output block:
//   - state_t          : controller states (idle, waiting for FIFO fill, running)
//   - DEF_*            : default data width, 640x480@60 raster timing, sync
//                        polarity and starvation colour
//   - cnt_width()      : counter width for a given period (never below 1 bit)
// -----------------------------------------------------------------------------
package fifo_video_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_FILL = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 32;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic        DEF_SYNC_POL      = 1'b0;
    localparam logic [23:0] DEF_UNDERFLOW_RGB = 24'hFF00FF;

    // Bits needed to count 0 .. total-1; a one-state counter still gets one bit.
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Raster position counters and stage-0 timing decode.
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-high reset (counters to origin)
//   run         in   1 = counters scan the raster, 0 = counters held at origin
//   act         out  current position is inside the active picture
//   hs          out  current position is inside the horizontal sync pulse
//   vs          out  current line is inside the vertical sync pulse
//   frame_first out  position is the first clock of the frame (h=0, v=0)
//   frame_last  out  position is the last clock of the frame
// -----------------------------------------------------------------------------
module video_timing_gen
    import fifo_video_out_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic act,
    output logic hs,
    output logic vs,
    output logic frame_first,
    output logic frame_last
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);
    // One extra bit so boundaries equal to the full period still compare correctly.
    localparam int HX      = HW + 1;
    localparam int VX      = VW + 1;

    localparam logic [HX-1:0] H_ACT_END  = HX'(H_ACTIVE);
    localparam logic [HX-1:0] H_SYNC_BEG = HX'(H_ACTIVE + H_FP);
    localparam logic [HX-1:0] H_SYNC_END = HX'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VX-1:0] V_ACT_END  = VX'(V_ACTIVE);
    localparam logic [VX-1:0] V_SYNC_BEG = VX'(V_ACTIVE + V_FP);
    localparam logic [VX-1:0] V_SYNC_END = VX'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt_r;
    logic [VW-1:0] v_cnt_r;
    logic [HX-1:0] h_ext_s;
    logic [VX-1:0] v_ext_s;
    logic          h_last_s;
    logic          v_last_s;

    assign h_ext_s  = {1'b0, h_cnt_r};
    assign v_ext_s  = {1'b0, v_cnt_r};
    assign h_last_s = (h_cnt_r == H_LAST);
    assign v_last_s = (v_cnt_r == V_LAST);

    // Raster counters: parked at the origin unless running, then scan line by line.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_r <= HW'(1'b0);
            v_cnt_r <= VW'(1'b0);
        end else if (!run) begin
            h_cnt_r <= HW'(1'b0);
            v_cnt_r <= VW'(1'b0);
        end else if (h_last_s) begin
            h_cnt_r <= HW'(1'b0);
            if (v_last_s) begin
                v_cnt_r <= VW'(1'b0);
            end else begin
                v_cnt_r <= v_cnt_r + VW'(1'b1);
            end
        end else begin
            h_cnt_r <= h_cnt_r + HW'(1'b1);
        end
    end

    assign act         = (h_ext_s < H_ACT_END) && (v_ext_s < V_ACT_END);
    assign hs          = (h_ext_s >= H_SYNC_BEG) && (h_ext_s < H_SYNC_END);
    assign vs          = (v_ext_s >= V_SYNC_BEG) && (v_ext_s < V_SYNC_END);
    assign frame_first = (h_cnt_r == HW'(1'b0)) && (v_cnt_r == VW'(1'b0));
    assign frame_last  = h_last_s && v_last_s;

endmodule

// File: rtl/fifo_video_out.sv
// -----------------------------------------------------------------------------
// fifo_video_out
// Streams pixels from a show-after-read FIFO onto a DE/HSYNC/VSYNC video port.
// The raster never stalls: a starved active pixel is painted UNDERFLOW_RGB and
// recorded in a sticky flag.
// Ports:
//   clk           in   clock (also the FIFO read clock)
//   reset         in   synchronous active-high reset
//   enable        in   level request for video output
//   rdreq         out  FIFO read request (combinational, stage 0)
//   q             in   FIFO data, valid the cycle after an accepted rdreq
//   rdempty       in   FIFO empty flag
//   vid_hsync     out  horizontal sync, SYNC_POL when asserted
//   vid_vsync     out  vertical sync, SYNC_POL when asserted
//   vid_de        out  active-video qualifier
//   vid_rgb       out  pixel (q[23:0]), 0 outside active video
//   frame_start   out  one-cycle pulse on the first output cycle of a frame
//   underflow     out  sticky starvation flag
//   underflow_clr in   clears underflow (a new starvation in the same cycle wins)
// -----------------------------------------------------------------------------
module fifo_video_out
    import fifo_video_out_pkg::*;
#(
    parameter int          DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int          H_ACTIVE      = DEF_H_ACTIVE,
    parameter int          H_FP          = DEF_H_FP,
    parameter int          H_SYNC        = DEF_H_SYNC,
    parameter int          H_BP          = DEF_H_BP,
    parameter int          V_ACTIVE      = DEF_V_ACTIVE,
    parameter int          V_FP          = DEF_V_FP,
    parameter int          V_SYNC        = DEF_V_SYNC,
    parameter int          V_BP          = DEF_V_BP,
    parameter logic        SYNC_POL      = DEF_SYNC_POL,
    parameter logic [23:0] UNDERFLOW_RGB = DEF_UNDERFLOW_RGB
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  rdreq,
    input  logic [DATA_WIDTH-1:0] q,
    input  logic                  rdempty,
    output logic                  vid_hsync,
    output logic                  vid_vsync,
    output logic                  vid_de,
    output logic [23:0]           vid_rgb,
    output logic                  frame_start,
    output logic                  underflow,
    input  logic                  underflow_clr
);

    localparam logic SYNC_OFF = ~SYNC_POL;

    state_t state_r;
    state_t state_nxt_s;
    logic   run_s;
    logic   act_s;
    logic   hs_s;
    logic   vs_s;
    logic   frame_first_s;
    logic   frame_last_s;
    logic   rd_s;
    logic   starve_s;

    logic   de_r;
    logic   hsync_r;
    logic   vsync_r;
    logic   rd_acc_r;
    logic   frame_start_r;
    logic   underflow_r;

    // Upper FIFO bits carry no pixel information.
    logic   unused_q_s;
    assign unused_q_s = ^q[DATA_WIDTH-1:24];

    assign run_s = (state_r == ST_RUN);

    video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .run         (run_s),
        .act         (act_s),
        .hs          (hs_s),
        .vs          (vs_s),
        .frame_first (frame_first_s),
        .frame_last  (frame_last_s)
    );

    // Stage 0: fetch a pixel for every active position the FIFO can serve.
    assign rd_s     = run_s & act_s & ~rdempty;
    assign starve_s = run_s & act_s & rdempty;
    assign rdreq    = rd_s;

    // Controller next state; a frame in progress always runs to its last clock.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_WAIT_FILL;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_FILL: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else if (!rdempty) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_WAIT_FILL;
                end
            end
            ST_RUN: begin
                if (frame_last_s && !enable) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Stage 1: timing qualifiers, read-accepted marker, frame pulse, sticky underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            de_r          <= 1'b0;
            hsync_r       <= SYNC_OFF;
            vsync_r       <= SYNC_OFF;
            rd_acc_r      <= 1'b0;
            frame_start_r <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            de_r          <= run_s & act_s;
            hsync_r       <= (run_s & hs_s) ? SYNC_POL : SYNC_OFF;
            vsync_r       <= (run_s & vs_s) ? SYNC_POL : SYNC_OFF;
            rd_acc_r      <= rd_s;
            frame_start_r <= run_s & frame_first_s;
            if (starve_s) begin
                underflow_r <= 1'b1;
            end else if (underflow_clr) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    // The FIFO presents read data one cycle after rdreq, which is exactly the
    // cycle the registered qualifiers describe, so q is selected here directly.
    always_comb begin
        vid_rgb = 24'h000000;
        if (rd_acc_r) begin
            vid_rgb = q[23:0];
        end else if (de_r) begin
            vid_rgb = UNDERFLOW_RGB;
        end else begin
            vid_rgb = 24'h000000;
        end
    end

    assign vid_de      = de_r;
    assign vid_hsync   = hsync_r;
    assign vid_vsync   = vsync_r;
    assign frame_start = frame_start_r;
    assign underflow   = underflow_r;

endmodule
